// File: rtl/munoc_upsizer_pkg.sv
// Shared definitions for the MUNOC narrow-to-wide W channel upsizer.
package munoc_upsizer_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Lane index width; kept at least 1 bit so RATIO==1 still has a legal counter.
    function automatic int unsigned lane_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/munoc_wdata_upsizer.sv
// Packs narrow AXI W beats into wide W beats on the address-selected lanes,
// behind a one-entry output register.
module munoc_wdata_upsizer
    import munoc_upsizer_pkg::*;
#(
    parameter int unsigned BW_ADDR   = 32,
    parameter int unsigned BW_NARROW = 32,
    parameter int unsigned BW_WIDE   = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [BW_ADDR-1:0]     cmd_addr,
    input  logic [1:0]             cmd_burst,
    input  logic [7:0]             cmd_len,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    input  logic [BW_NARROW-1:0]   s_wdata,
    input  logic [BW_NARROW/8-1:0] s_wstrb,
    input  logic                   s_wlast,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    output logic [BW_WIDE-1:0]     m_wdata,
    output logic [BW_WIDE/8-1:0]   m_wstrb,
    output logic                   m_wlast,
    output logic                   err_pulse
);

    localparam int unsigned RATIO = BW_WIDE / BW_NARROW;
    localparam int unsigned LW    = lane_width(RATIO);
    localparam int unsigned LSB   = $clog2(BW_NARROW / 8);
    localparam int unsigned NSTRB = BW_NARROW / 8;
    localparam int unsigned WSTRB = BW_WIDE / 8;

    state_t             state_q, state_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic               fixed_q, fixed_d;
    logic [7:0]         rem_q, rem_d;
    logic [BW_WIDE-1:0] acc_data_q, acc_data_d, merged_data;
    logic [WSTRB-1:0]   acc_strb_q, acc_strb_d, merged_strb;
    logic               wvalid_d, wlast_d, err_d;
    logic [BW_WIDE-1:0] wdata_d;
    logic [WSTRB-1:0]   wstrb_d;
    logic               beat_end, beat_close;
    logic               unused_addr;

    assign unused_addr = ^cmd_addr;
    assign cmd_ready   = (state_q == IDLE);
    assign s_wready    = (state_q == PACK) && (!m_wvalid || m_wready);

    // Next-state, accumulator and output register update
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        fixed_d    = fixed_q;
        rem_d      = rem_q;
        acc_data_d = acc_data_q;
        acc_strb_d = acc_strb_q;
        wvalid_d   = m_wvalid;
        wdata_d    = m_wdata;
        wstrb_d    = m_wstrb;
        wlast_d    = m_wlast;
        err_d      = 1'b0;

        merged_data = acc_data_q;
        merged_strb = acc_strb_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane_q == LW'(i)) begin
                merged_data[i*BW_NARROW +: BW_NARROW] = s_wdata;
                merged_strb[i*NSTRB +: NSTRB]         = s_wstrb;
            end
        end

        beat_end   = (rem_q == 8'd0) || s_wlast;
        beat_close = fixed_q || (lane_q == LW'(RATIO - 1)) || beat_end;

        if (m_wvalid && m_wready) begin
            wvalid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    lane_d     = LW'(cmd_addr[LSB +: LW]) & LW'(RATIO - 1);
                    fixed_d    = (cmd_burst == BURST_FIXED);
                    rem_d      = cmd_len;
                    acc_data_d = '0;
                    acc_strb_d = '0;
                    state_d    = PACK;
                end
            end
            PACK: begin
                if (s_wvalid && s_wready) begin
                    if (beat_close) begin
                        wvalid_d   = 1'b1;
                        wdata_d    = merged_data;
                        wstrb_d    = merged_strb;
                        wlast_d    = beat_end;
                        acc_data_d = '0;
                        acc_strb_d = '0;
                    end else begin
                        acc_data_d = merged_data;
                        acc_strb_d = merged_strb;
                    end
                    if (!fixed_q) begin
                        lane_d = (lane_q == LW'(RATIO - 1)) ? '0 : lane_q + LW'(1);
                    end
                    rem_d = rem_q - 8'd1;
                    if (beat_end) begin
                        err_d   = s_wlast != (rem_q == 8'd0);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_wvalid && m_wready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            fixed_q    <= 1'b0;
            rem_q      <= '0;
            acc_data_q <= '0;
            acc_strb_q <= '0;
            m_wvalid   <= 1'b0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            m_wlast    <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            fixed_q    <= fixed_d;
            rem_q      <= rem_d;
            acc_data_q <= acc_data_d;
            acc_strb_q <= acc_strb_d;
            m_wvalid   <= wvalid_d;
            m_wdata    <= wdata_d;
            m_wstrb    <= wstrb_d;
            m_wlast    <= wlast_d;
            err_pulse  <= err_d;
        end
    end

endmodule

// File: tb/tb_munoc_wdata_upsizer.sv
// Randomized bench for munoc_wdata_upsizer against a queue-based packing model.
module tb_munoc_wdata_upsizer;

    localparam int R = 4;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  s;
        logic         l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  cmd_addr;
    logic [1:0]   cmd_burst;
    logic [7:0]   cmd_len;
    logic         s_wvalid, s_wready, s_wlast;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         m_wvalid, m_wready, m_wlast, err_pulse;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;

    exp_t        exp_q[$];
    logic [31:0] bd[256];
    logic [3:0]  bs[256];
    int checks = 0, failures = 0;
    int err_seen = 0, err_exp = 0;
    int cyc = 0, hold_until = 0, gap_max = 0;
    bit rdy_rand = 1'b0;

    munoc_wdata_upsizer #(.BW_ADDR(32), .BW_NARROW(32), .BW_WIDE(128)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Sink: back-pressure forced low until hold_until, else random or always ready
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rst || cyc < hold_until) m_wready = 1'b0;
        else if (rdy_rand)           m_wready = ($urandom_range(0, 3) != 0);
        else                         m_wready = 1'b1;
    end

    // Compare process: every wide handshake must match the head of the model queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (err_pulse) err_seen++;
            if (m_wvalid && !m_wready) check("stall_s_wready", 128'(s_wready), 128'd0);
            if (m_wvalid && m_wready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 128'd1, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_wdata", m_wdata, e.d);
                    check("m_wstrb", 128'(m_wstrb), 128'(e.s));
                    check("m_wlast", 128'(m_wlast), 128'(e.l));
                end
            end
        end
    end

    // Behavioural packing of one burst from bd/bs into expected wide beats
    task automatic model_burst(input logic [31:0] addr, input logic [1:0] burst,
                               input int len, input int last_at, output int pushed);
        int lane;
        int n;
        logic [127:0] d;
        logic [15:0] s;
        exp_t t;
        lane = int'((addr >> 2) & 32'd3);
        n = ((last_at < len) ? last_at : len) + 1;
        d = '0;
        s = '0;
        pushed = 0;
        for (int i = 0; i < n; i++) begin
            d[lane*32 +: 32] = bd[i];
            s[lane*4 +: 4] = bs[i];
            if (burst == 2'd0 || lane == R - 1 || i == n - 1) begin
                t.d = d; t.s = s; t.l = (i == n - 1);
                exp_q.push_back(t);
                pushed++;
                d = '0;
                s = '0;
            end
            if (burst != 2'd0) lane = (lane + 1) % R;
        end
        if (last_at != len) err_exp++;
    endtask

    task automatic drive_burst(input logic [31:0] addr, input logic [1:0] burst,
                               input int len, input int last_at, input int abort_after);
        int n;
        int budget;
        int gap;
        n = ((last_at < len) ? last_at : len) + 1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_burst = burst; cmd_len = 8'(len);
        budget = 0;
        do begin @(negedge clk); budget++; end while (!cmd_ready && budget < 200);
        if (!cmd_ready) check("cmd_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = $urandom;
        for (int i = 0; i < n; i++) begin
            if (i == abort_after) return;
            gap = $urandom_range(0, gap_max);
            for (int g = gap; g > 0; g--) begin @(posedge clk); #1; end
            s_wvalid = 1'b1; s_wdata = bd[i]; s_wstrb = bs[i]; s_wlast = (i == last_at);
            budget = 0;
            do begin @(negedge clk); budget++; end while (!s_wready && budget < 200);
            if (!s_wready) check("beat_timeout", 128'd0, 128'd1);
            @(posedge clk); #1;
            s_wvalid = 1'b0; s_wlast = 1'b0; s_wdata = $urandom;
        end
        budget = 0;
        do begin @(negedge clk); #1; budget++; end
        while (!(cmd_ready && exp_q.size() == 0) && budget < 500);
        if (budget >= 500) begin
            check("done_timeout", 128'd0, 128'd1);
            exp_q.delete();
        end
        check("err_count", 128'(err_seen), 128'(err_exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, base, len, last_at;
        logic [31:0] addr;
        logic [1:0] burst;

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_len = '0;
        s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 128'(cmd_ready), 128'd1);
        check("rst_s_wready", 128'(s_wready), 128'd0);
        check("rst_m_wvalid", 128'(m_wvalid), 128'd0);
        check("rst_m_wdata", m_wdata, 128'd0);
        check("rst_m_wstrb", 128'(m_wstrb), 128'd0);
        check("rst_m_wlast", 128'(m_wlast), 128'd0);
        check("rst_err", 128'(err_pulse), 128'd0);
        rst = 1'b0;

        // Full INCR window from lane 0
        for (int i = 0; i < 4; i++) begin bd[i] = {4{8'hA0 + 8'(i)}}; bs[i] = 4'hF; end
        base = exp_q.size();
        model_burst(32'h0, 2'd1, 3, 3, np);
        check("pin1_n", 128'(np), 128'd1);
        check("pin1_d", exp_q[base].d, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        check("pin1_s", 128'(exp_q[base].s), 128'hFFFF);
        check("pin1_l", 128'(exp_q[base].l), 128'd1);
        drive_burst(32'h0, 2'd1, 3, 3, -1);

        // INCR starting at lane 2 spills into a second wide beat
        for (int i = 0; i < 4; i++) begin bd[i] = {4{8'hB0 + 8'(i)}}; bs[i] = 4'hF; end
        base = exp_q.size();
        model_burst(32'h8, 2'd1, 3, 3, np);
        check("pin2_n", 128'(np), 128'd2);
        check("pin2_d0", exp_q[base].d, 128'hB1B1B1B1_B0B0B0B0_00000000_00000000);
        check("pin2_s0", 128'(exp_q[base].s), 128'hFF00);
        check("pin2_l0", 128'(exp_q[base].l), 128'd0);
        check("pin2_s1", 128'(exp_q[base+1].s), 128'h00FF);
        check("pin2_l1", 128'(exp_q[base+1].l), 128'd1);
        drive_burst(32'h8, 2'd1, 3, 3, -1);

        // FIXED burst on lane 1: one wide beat per narrow beat
        for (int i = 0; i < 2; i++) begin bd[i] = {4{8'hC0 + 8'(i)}}; bs[i] = 4'hF; end
        base = exp_q.size();
        model_burst(32'h4, 2'd0, 1, 1, np);
        check("pin3_n", 128'(np), 128'd2);
        check("pin3_d0", exp_q[base].d, 128'h00000000_00000000_C0C0C0C0_00000000);
        check("pin3_s0", 128'(exp_q[base].s), 128'h00F0);
        check("pin3_s1", 128'(exp_q[base+1].s), 128'h00F0);
        check("pin3_l1", 128'(exp_q[base+1].l), 128'd1);
        drive_burst(32'h4, 2'd0, 1, 1, -1);

        // Same as the first burst, with the sink stalled across the first output
        for (int i = 0; i < 4; i++) begin bd[i] = {4{8'hA0 + 8'(i)}}; bs[i] = 4'hF; end
        hold_until = cyc + 12;
        model_burst(32'h0, 2'd1, 3, 3, np);
        drive_burst(32'h0, 2'd1, 3, 3, -1);

        // Early s_wlast on the second beat
        for (int i = 0; i < 4; i++) begin bd[i] = {4{8'hD0 + 8'(i)}}; bs[i] = 4'hF; end
        base = exp_q.size();
        model_burst(32'h0, 2'd1, 3, 1, np);
        check("pin5_n", 128'(np), 128'd1);
        check("pin5_s", 128'(exp_q[base].s), 128'h00FF);
        check("pin5_l", 128'(exp_q[base].l), 128'd1);
        drive_burst(32'h0, 2'd1, 3, 1, -1);
        check("case5_cmd_ready", 128'(cmd_ready), 128'd1);

        // Missing s_wlast on the final beat
        for (int i = 0; i < 2; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
        model_burst(32'h0, 2'd1, 1, 5, np);
        drive_burst(32'h0, 2'd1, 1, 5, -1);

        // Reset in the middle of a burst, then a clean burst
        for (int i = 0; i < 4; i++) begin bd[i] = {4{8'hA0 + 8'(i)}}; bs[i] = 4'hF; end
        drive_burst(32'h0, 2'd1, 3, 3, 2);
        #2;
        rst = 1'b1;
        #1;
        check("rst6_cmd_ready", 128'(cmd_ready), 128'd1);
        check("rst6_s_wready", 128'(s_wready), 128'd0);
        check("rst6_m_wvalid", 128'(m_wvalid), 128'd0);
        check("rst6_m_wstrb", 128'(m_wstrb), 128'd0);
        check("rst6_m_wlast", 128'(m_wlast), 128'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin bd[i] = {4{8'hE0 + 8'(i)}}; bs[i] = 4'hF; end
        base = exp_q.size();
        model_burst(32'h4, 2'd1, 2, 2, np);
        check("pin6_s", 128'(exp_q[base].s), 128'hFFF0);
        drive_burst(32'h4, 2'd1, 2, 2, -1);

        // Randomized bursts with random back-pressure and source gaps
        rdy_rand = 1'b1;
        gap_max = 2;
        for (int k = 0; k < 60; k++) begin
            addr = $urandom;
            burst = 2'($urandom_range(0, 2));
            len = $urandom_range(0, 9);
            last_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 2) : len;
            for (int i = 0; i <= len; i++) begin bd[i] = $urandom; bs[i] = 4'($urandom); end
            model_burst(addr, burst, len, last_at, np);
            drive_burst(addr, burst, len, last_at, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
